// File: rtl/seed_random_3_pkg.sv
// Shared definitions for the seed_random_3 control path: FSM states,
// default parameter values and the SEND length counter width.
package seed_random_3_pkg;

    // FSM state; the encoding is visible on state_o (0 = IDLE, 1 = SEND)
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int unsigned SEND_LEN_DEF = 1;
    localparam int unsigned CNT_W_DEF    = 8;

    // SEND_LEN is at most 255, so an 8-bit down-counter holds SEND_LEN-1
    localparam int unsigned LEN_W = 8;

    // Counter preload for a SEND phase lasting send_len cycles
    function automatic logic [LEN_W-1:0] len_load(input int unsigned send_len);
        return LEN_W'(send_len - 1);
    endfunction

endpackage

// File: rtl/seed_random_3_edge_det.sv
// Request edge detector for the seed_random_3 control path.
// Optional macro SEED_RANDOM_REQ_SYNC_EN inserts a 2-flop synchronizer
// ahead of the detector, adding two cycles of latency.
module seed_random_3_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic rise_o
);

    logic req_src;
    logic req_prev_q;
    logic rise_q;

`ifdef SEED_RANDOM_REQ_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer for the asynchronous request level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], req_i};
        end
    end

    assign req_src = sync_q[1];
`else
    assign req_src = req_i;
`endif

    // Registered rising-edge detect; prev clears on reset so a level held
    // high across reset release is seen as a fresh request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_prev_q <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            req_prev_q <= req_src;
            rise_q     <= req_src & ~req_prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/seed_random_3_ctrl_path.sv
// Control-path FSM for the seed_random_3 card-draw unit: turns a request
// rising edge into a SEND phase of SEND_LEN cycles, strobes its first
// cycle and counts accepted requests. Edges seen during SEND are dropped.
// Optional macro SEED_RANDOM_REQ_SYNC_EN (see seed_random_3_edge_det).
module seed_random_3_ctrl_path
    import seed_random_3_pkg::*;
#(
    parameter int unsigned SEND_LEN = SEND_LEN_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk_cp_i,
    input  logic             rst_cp_i,
    input  logic             req_card_state_cp,
    output logic             state_o,
    output logic             send_stb_o,
    output logic [CNT_W-1:0] req_cnt_o
);

    localparam logic [LEN_W-1:0] LEN_PRELOAD = len_load(SEND_LEN);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               stb_q;
    logic               req_rise;

    seed_random_3_edge_det u_edge_det (
        .clk_i  (clk_cp_i),
        .rst_i  (rst_cp_i),
        .req_i  (req_card_state_cp),
        .rise_o (req_rise)
    );

    // FSM with length counter, request counter and first-cycle strobe
    always_ff @(posedge clk_cp_i or posedge rst_cp_i) begin
        if (rst_cp_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_rise) begin
                        state_q <= SEND;
                        len_q   <= LEN_PRELOAD;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        stb_q   <= 1'b1;
                    end
                end
                SEND: begin
                    if (len_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        len_q <= len_q - LEN_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o    = logic'(state_q);
    assign send_stb_o = stb_q;
    assign req_cnt_o  = cnt_q;

endmodule

// File: tb/tb_seed_random_3_ctrl_path.sv
// Bench for seed_random_3_ctrl_path: two instances (SEND_LEN=1/CNT_W=8 and
// SEND_LEN=4/CNT_W=2) share one random request stream. A window-based
// model predicts each cycle's outputs into queues; a monitor compares.
module tb_seed_random_3_ctrl_path;

    localparam int unsigned LEN_A = 1;
    localparam int unsigned CW_A  = 8;
    localparam int unsigned LEN_B = 4;
    localparam int unsigned CW_B  = 2;
`ifdef SEED_RANDOM_REQ_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct packed {
        logic       st;
        logic       stb;
        logic [7:0] cnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req = 1'b0;
    logic            st_a, stb_a, st_b, stb_b;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;

    int   vectors     = 0;
    int   miscompares = 0;

    exp_t qa[$];
    exp_t qb[$];
    bit   lvl[$];
    int   k;
    int   last_start[2];
    int   cnt_m[2];
    int   lens[2];
    int   cws[2];

    always #5 clk = ~clk;

    seed_random_3_ctrl_path #(.SEND_LEN(LEN_A), .CNT_W(CW_A)) u_dut_a (
        .clk_cp_i          (clk),
        .rst_cp_i          (rst),
        .req_card_state_cp (req),
        .state_o           (st_a),
        .send_stb_o        (stb_a),
        .req_cnt_o         (cnt_a)
    );

    seed_random_3_ctrl_path #(.SEND_LEN(LEN_B), .CNT_W(CW_B)) u_dut_b (
        .clk_cp_i          (clk),
        .rst_cp_i          (rst),
        .req_card_state_cp (req),
        .state_o           (st_b),
        .send_stb_o        (stb_b),
        .req_cnt_o         (cnt_b)
    );

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got st=%b stb=%b cnt=%0d, expected st=%b stb=%b cnt=%0d",
                     name, $time, act[9], act[8], act[7:0], exp_v[9], exp_v[8], exp_v[7:0]);
        end
    endtask

    task automatic model_reset();
        k = 0;
        lvl.delete();
        qa.delete();
        qb.delete();
        for (int d = 0; d < 2; d++) begin
            last_start[d] = -1000;
            cnt_m[d]      = 0;
        end
    endtask

    // Expected outputs after edge k: a rise sampled at edge j is accepted at
    // edge k if no SEND phase was active after edge k-1; a phase started at
    // edge s keeps state high after edges s..s+len-1.
    task automatic model_edge(input int d, output exp_t e);
        int j;
        bit rise;
        j    = k - 1 - EXTRA;
        rise = 1'b0;
        if (j >= 0) rise = lvl[j] && !((j > 0) ? lvl[j-1] : 1'b0);
        if (rise && (k - 1 >= last_start[d] + lens[d])) begin
            last_start[d] = k;
            cnt_m[d]      = (cnt_m[d] + 1) % (1 << cws[d]);
        end
        e.st  = (k >= last_start[d]) && (k < last_start[d] + lens[d]);
        e.stb = (k == last_start[d]);
        e.cnt = 8'(cnt_m[d]);
    endtask

    // Called at a negedge: drive the level sampled at the next posedge and
    // queue the outputs expected right after it
    task automatic cycle(input bit level);
        exp_t e;
        req = level;
        lvl.push_back(level);
        model_edge(0, e);
        qa.push_back(e);
        model_edge(1, e);
        qb.push_back(e);
        k++;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {st_a, stb_a, 8'(cnt_a)}, 10'd0);
        check({tag, "_b"}, {st_b, stb_b, 8'(cnt_b)}, 10'd0);
    endtask

    // Monitor: compare every post-edge output against the queued prediction
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("dut_a", {st_a, stb_a, 8'(cnt_a)}, e);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("dut_b", {st_b, stb_b, 8'(cnt_b)}, e);
            end
        end
    end

    initial begin
        int guard;
        lens[0] = LEN_A; lens[1] = LEN_B;
        cws[0]  = CW_A;  cws[1]  = CW_B;
        model_reset();

        // Reset held with the request toggling
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = ~req;
            #1 check_zero("reset_hold");
        end
        req = 1'b0;
        rst = 1'b0;
        repeat (4) cycle(1'b0);

        // Held levels: 5 high / 5 low, three times
        for (int i = 0; i < 3; i++) begin
            repeat (5) cycle(1'b1);
            repeat (5) cycle(1'b0);
        end

        // Randomized request waveform including 1-cycle pulses
        for (int s = 0; s < 60; s++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, 8);
            lo = $urandom_range(1, 8);
            repeat (hi) cycle(1'b1);
            repeat (lo) cycle(1'b0);
        end

        // Mid-SEND reset: raise request, assert reset in dut_b's 2nd SEND cycle
        repeat (8) cycle(1'b0);
        guard = 0;
        while (!(k - 1 == last_start[1] + 1) && guard < 20) begin
            cycle(1'b1);
            guard++;
        end
        if (guard >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL mid_send_setup: no SEND phase started within 20 cycles");
        end
        #2;
        rst = 1'b1;
        #1 check_zero("mid_send_reset");
        model_reset();
        req = 1'b0;
        @(negedge clk);
        #1 check_zero("mid_send_hold");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) cycle(1'b0);

        // Request held high across reset release counts as an edge
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) cycle(1'b1);
        repeat (6) cycle(1'b0);
        for (int s = 0; s < 20; s++) begin
            repeat ($urandom_range(1, 3)) cycle(1'b1);
            repeat ($urandom_range(1, 6)) cycle(1'b0);
        end

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
